ppu_ri: RTL
===========

Name: ppu_ri

Overview:
- CPU-side register interface of the PPU: decodes $2000-$2007 accesses from the CPU bus and holds PPUCTRL, PPUMASK, PPUSTATUS, OAMADDR, the scroll/address registers (t, v, fine x, write toggle w) and the PPUDATA read buffer.
- Sits upstream of the PPU memory port. Turns $2007 accesses into single read/write requests and exports control/scroll state to the rendering pipeline.

Parameters:
- VRAM_AW, 14, VRAM address width.
- OAM_AW, 8, OAM address width.

Ports:
- clk  in  1  25 MHz system clock
- rst  in  1  synchronous, active-high reset
- ri_sel_in  in  3  register select (#2000-#2007)
- ri_ncs_in  in  1  register chip select, active low
- ri_r_nw_in  in  1  1=CPU read, 0=CPU write
- ri_d_in  in  8  CPU write data
- ri_d_out  out  8  CPU read data
- vblank_set_in  in  1  1-cycle pulse, start of vblank
- vblank_clr_in  in  1  1-cycle pulse, pre-render line
- spr0_hit_in  in  1  sprite-0 hit level from renderer
- spr_ovf_in  in  1  sprite overflow level from renderer
- vram_d_in  in  8  memory read data, valid with vram_ack_in
- vram_ack_in  in  1  1-cycle completion of the outstanding request
- vram_addr_out  out  14  request address
- vram_d_out  out  8  write data
- vram_rd_req_out  out  1  read request, held until ack
- vram_wr_req_out  out  1  write request, held until ack
- oam_addr_out  out  8  OAM address
- oam_d_out  out  8  OAM write data
- oam_wr_out  out  1  1-cycle OAM write strobe
- oam_d_in  in  8  OAM read data
- ctrl_out  out  8  PPUCTRL
- mask_out  out  8  PPUMASK
- t_out  out  15  temporary VRAM address
- v_out  out  15  current VRAM address
- fine_x_out  out  3  fine X scroll
- nmi_out  out  1  NMI request, active high

Behaviour:
- Reset: every register, w, buffer, io latch, ri_d_out and all req/strobe outputs are 0. FSM goes to IDLE.
- Access event: exactly one per CPU access.
  - Fires on the first cycle with ri_ncs_in=0 after a cycle with ri_ncs_in=1.
  - The ncs history register resets to 1.
  - sel/r_nw/d are sampled in the event cycle. All side effects occur on that cycle's edge.
  - ri_d_out is registered one cycle later and held until the next read event.
- Io latch: every write loads ri_d_in. Reads of write-only registers ($2000/1/3/5/6) return the latch.
- Per-register behaviour:
  - $2000 W: ctrl<=d, t[11:10]<=d[1:0].
  - $2001 W: mask<=d.
  - $2002 R: returns {vblank, spr0_hit_in, spr_ovf_in, latch[4:0]}; then vblank<=0, w<=0.
  - $2003 W: oamaddr<=d.
  - $2004 W: oam_d_out<=d, oam_wr_out pulses 1 cycle, oamaddr+=1 (wraps 8'hFF->0).
  - $2004 R: returns oam_d_in, no increment.
  - $2005 W, w=0: t[4:0]<=d[7:3], x<=d[2:0], w<=1.
  - $2005 W, w=1: t[14:12]<=d[2:0], t[9:5]<=d[7:3], w<=0.
  - $2006 W, w=0: t[13:8]<=d[5:0], t[14]<=0, w<=1.
  - $2006 W, w=1: t[7:0]<=d, v<=new t, w<=0.
  - $2007 W: FSM IDLE->WR. Registers vram_addr_out<=v[13:0] and vram_d_out<=d, asserts wr_req. Then v+=ctrl[2]?32:1, wrapping mod 2^15.
  - $2007 R: returns buffer. FSM IDLE->RD: registers addr<=v[13:0], asserts rd_req, then increments v as for writes.
- FSM (IDLE, RD, WR):
  - Req deasserts on the ack cycle and the FSM returns to IDLE.
  - In RD the ack cycle also does buffer<=vram_d_in.
  - A $2007 event while not IDLE is dropped entirely: no request, no v increment. Other registers are still serviced.
  - v changes while a request is in flight do not affect the latched address.
- vblank flag:
  - set by vblank_set_in, cleared by vblank_clr_in, $2002 read or rst.
  - clr and set in the same cycle: clear wins.
  - $2002 read in the same cycle as set: returns bit7=0 and the flag stays 0 (NMI suppression).
- nmi_out = vblank & ctrl[7], registered. Writing ctrl[7]=1 while vblank=1 raises nmi_out on the next cycle.
- Reset mid-request: req drops immediately, FSM goes to IDLE, any later ack is ignored.

Optional Feature:
- PPU_RI_PALETTE_BYPASS_EN defined:
  - A $2007 read with v[13:8]=6'h3F loads ri_d_out from vram_d_in at ack instead of from the buffer.
  - The buffer still loads from vram_d_in at the same ack.
  - ri_d_out holds its previous value until the ack.
- Not defined: palette reads behave like all other reads and return the buffer.

Decomposition:
- Package ppu_ri_pkg:
  - register index constants REG_CTRL..REG_DATA (0-7)
  - PPUCTRL/PPUMASK bit-position constants (CTRL_NMI_EN=7, CTRL_INC32=2)
  - FSM state enum
- Sub-module ppu_ri_scroll: owns t, v, x, w; takes decoded $2000/$2002/$2005/$2006 writes and the increment strobe.

Test Plan:
- Reset, then $2002 read -> ri_d_out=8'h00; all req outputs 0.
- $2006 W 8'h21, $2006 W 8'h08 -> v=15'h2108. Then $2007 W 8'h55 -> one wr_req with addr 14'h2108, data 8'h55; v=15'h2109 (ctrl[2]=0), or 15'h2128 after $2000 W 8'h04 (ctrl[2]=1).
- $2005 W 8'h7D, $2005 W 8'h5E -> t[4:0]=5'h0F, x=3'h5, t[9:5]=5'h0B, t[14:12]=3'h6, w=0.
- v=15'h2000, memory returns 8'hAB, then 8'hCD -> first $2007 read returns stale buffer 8'h00, second returns 8'hAB. With PPU_RI_PALETTE_BYPASS_EN, a read at 15'h3F00 returns the data directly.
- Event ordering:
  - $2000 W 8'h80, then vblank_set_in -> nmi_out=1; then $2002 read -> bit7=1, nmi_out=0, w=0.
  - vblank_set_in on the same cycle as a $2002 read event -> returns bit7=0, no NMI.
- A second $2007 write issued before ack -> ignored, v incremented only once; rst asserted mid-request -> wr_req=0 next cycle.

Source files
------------

// File: rtl/ppu_ri_pkg.sv
// ppu_ri_pkg: shared definitions for the PPU CPU-side register interface.
//   - REG_* : register index within the $2000-$2007 window
//   - CTRL_*: bit positions inside PPUCTRL that this block acts on
//   - state_t: memory-port request FSM states
package ppu_ri_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_MASK    = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_OAMADDR = 3'd3;
    localparam logic [2:0] REG_OAMDATA = 3'd4;
    localparam logic [2:0] REG_SCROLL  = 3'd5;
    localparam logic [2:0] REG_ADDR    = 3'd6;
    localparam logic [2:0] REG_DATA    = 3'd7;

    localparam int CTRL_NMI_EN = 7;
    localparam int CTRL_INC32  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

endpackage

// File: rtl/ppu_ri_scroll.sv
// ppu_ri_scroll: owns the loopy scroll/address state of the PPU.
//   clk, rst     : clock, synchronous active-high reset
//   wr_ctrl      : $2000 write (nametable select bits into t)
//   rd_status    : $2002 read (clears the write toggle)
//   wr_scroll    : $2005 write
//   wr_addr      : $2006 write
//   inc, inc32   : advance v after a $2007 access, by 32 when inc32 else by 1
//   d            : CPU write data
//   t, v, fine_x : temporary address, current address, fine X scroll
module ppu_ri_scroll (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ctrl,
    input  logic        rd_status,
    input  logic        wr_scroll,
    input  logic        wr_addr,
    input  logic        inc,
    input  logic        inc32,
    input  logic [7:0]  d,
    output logic [14:0] t,
    output logic [14:0] v,
    output logic [2:0]  fine_x
);

    // Shared first/second write toggle for $2005 and $2006.
    logic w;

    // Only one decoded access can be active per cycle, so the branches
    // below never compete for the same bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            t      <= '0;
            v      <= '0;
            fine_x <= '0;
            w      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                t[11:10] <= d[1:0];
            end
            if (rd_status) begin
                w <= 1'b0;
            end
            if (wr_scroll) begin
                if (!w) begin
                    t[4:0] <= d[7:3];
                    fine_x <= d[2:0];
                    w      <= 1'b1;
                end else begin
                    t[14:12] <= d[2:0];
                    t[9:5]   <= d[7:3];
                    w        <= 1'b0;
                end
            end
            if (wr_addr) begin
                if (!w) begin
                    t[13:8] <= d[5:0];
                    t[14]   <= 1'b0;
                    w       <= 1'b1;
                end else begin
                    t[7:0] <= d;
                    v      <= {t[14:8], d};
                    w      <= 1'b0;
                end
            end
            if (inc) begin
                v <= v + (inc32 ? 15'd32 : 15'd1);
            end
        end
    end

endmodule

// File: rtl/ppu_ri.sv
// ppu_ri: CPU-side register interface of the PPU ($2000-$2007).
//   CPU bus   : ri_sel_in, ri_ncs_in, ri_r_nw_in, ri_d_in -> ri_d_out
//   Status    : vblank_set_in, vblank_clr_in, spr0_hit_in, spr_ovf_in
//   VRAM port : vram_addr_out, vram_d_out, vram_rd_req_out, vram_wr_req_out,
//               vram_d_in, vram_ack_in (one outstanding request at a time)
//   OAM port  : oam_addr_out, oam_d_out, oam_wr_out, oam_d_in
//   Exports   : ctrl_out, mask_out, t_out, v_out, fine_x_out, nmi_out
// Optional build macro PPU_RI_PALETTE_BYPASS_EN: $2007 reads from the
// palette range ($3Fxx) return the fetched byte directly at ack.
module ppu_ri
    import ppu_ri_pkg::*;
#(
    parameter int VRAM_AW = 14,
    parameter int OAM_AW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         ri_sel_in,
    input  logic               ri_ncs_in,
    input  logic               ri_r_nw_in,
    input  logic [7:0]         ri_d_in,
    output logic [7:0]         ri_d_out,
    input  logic               vblank_set_in,
    input  logic               vblank_clr_in,
    input  logic               spr0_hit_in,
    input  logic               spr_ovf_in,
    input  logic [7:0]         vram_d_in,
    input  logic               vram_ack_in,
    output logic [VRAM_AW-1:0] vram_addr_out,
    output logic [7:0]         vram_d_out,
    output logic               vram_rd_req_out,
    output logic               vram_wr_req_out,
    output logic [OAM_AW-1:0]  oam_addr_out,
    output logic [7:0]         oam_d_out,
    output logic               oam_wr_out,
    input  logic [7:0]         oam_d_in,
    output logic [7:0]         ctrl_out,
    output logic [7:0]         mask_out,
    output logic [14:0]        t_out,
    output logic [14:0]        v_out,
    output logic [2:0]         fine_x_out,
    output logic               nmi_out
);

    logic              ncs_q;
    logic              access, rd_ev, wr_ev;
    logic              wr_ctrl, wr_mask, rd_status, wr_oamaddr, wr_oamdata;
    logic              wr_scroll, wr_addr;
    logic              data_go, rd_ack, pal_hit, pal_pend;
    logic [7:0]        latch, ctrl, mask, buffer, rd_data;
    logic [OAM_AW-1:0] oamaddr, oam_wr_addr;
    logic              vblank, vblank_nx;
    logic [14:0]       v;
    state_t            state, state_nx;

    // One access event per chip-select falling edge.
    assign access = ~ri_ncs_in & ncs_q;
    assign rd_ev  = access & ri_r_nw_in;
    assign wr_ev  = access & ~ri_r_nw_in;

    assign wr_ctrl    = wr_ev & (ri_sel_in == REG_CTRL);
    assign wr_mask    = wr_ev & (ri_sel_in == REG_MASK);
    assign rd_status  = rd_ev & (ri_sel_in == REG_STATUS);
    assign wr_oamaddr = wr_ev & (ri_sel_in == REG_OAMADDR);
    assign wr_oamdata = wr_ev & (ri_sel_in == REG_OAMDATA);
    assign wr_scroll  = wr_ev & (ri_sel_in == REG_SCROLL);
    assign wr_addr    = wr_ev & (ri_sel_in == REG_ADDR);

    // A $2007 access only counts when no request is in flight.
    assign data_go = access & (ri_sel_in == REG_DATA) & (state == ST_IDLE);
    assign rd_ack  = vram_ack_in & (state == ST_RD);

    assign ctrl_out = ctrl;
    assign mask_out = mask;
    assign v_out    = v;

    // During the write strobe the OAM sees the address that was written,
    // not the already-incremented OAMADDR.
    assign oam_addr_out = oam_wr_out ? oam_wr_addr : oamaddr;

    ppu_ri_scroll u_scroll (
        .clk       (clk),
        .rst       (rst),
        .wr_ctrl   (wr_ctrl),
        .rd_status (rd_status),
        .wr_scroll (wr_scroll),
        .wr_addr   (wr_addr),
        .inc       (data_go),
        .inc32     (ctrl[CTRL_INC32]),
        .d         (ri_d_in),
        .t         (t_out),
        .v         (v),
        .fine_x    (fine_x_out)
    );

    // Request FSM: requests are decoded straight from the state so they
    // drop on the ack edge and on reset without an extra cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        vram_rd_req_out = 1'b0;
        vram_wr_req_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (data_go) begin
                    state_nx = ri_r_nw_in ? ST_RD : ST_WR;
                end
            end
            ST_RD: begin
                vram_rd_req_out = 1'b1;
                if (vram_ack_in) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WR: begin
                vram_wr_req_out = 1'b1;
                if (vram_ack_in) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Clear beats set, and a $2002 read racing the set also wins, which
    // suppresses the NMI for that frame.
    always_comb begin
        vblank_nx = vblank;
        if (vblank_set_in) begin
            vblank_nx = 1'b1;
        end
        if (rd_status || vblank_clr_in) begin
            vblank_nx = 1'b0;
        end
    end

    // Read data as seen at the event; write-only registers echo the io latch.
    always_comb begin
        rd_data = latch;
        case (ri_sel_in)
            REG_STATUS:  rd_data = {vblank, spr0_hit_in, spr_ovf_in, latch[4:0]};
            REG_OAMDATA: rd_data = oam_d_in;
            REG_DATA:    rd_data = buffer;
            default:     rd_data = latch;
        endcase
    end

`ifdef PPU_RI_PALETTE_BYPASS_EN
    // Palette reads defer ri_d_out until the fetched byte arrives.
    assign pal_hit = data_go & ri_r_nw_in & (v[13:8] == 6'h3F);

    always_ff @(posedge clk) begin
        if (rst) begin
            pal_pend <= 1'b0;
        end else if (pal_hit) begin
            pal_pend <= 1'b1;
        end else if (rd_ack) begin
            pal_pend <= 1'b0;
        end
    end
`else
    assign pal_hit  = 1'b0;
    assign pal_pend = 1'b0;
`endif

    // CPU-visible registers, OAM port, request payload and NMI.
    // nmi_out tracks the next-state flag and enable so that it moves on the
    // same edge as the access that changes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_q         <= 1'b1;
            latch         <= '0;
            ctrl          <= '0;
            mask          <= '0;
            oamaddr       <= '0;
            oam_wr_addr   <= '0;
            oam_d_out     <= '0;
            oam_wr_out    <= 1'b0;
            buffer        <= '0;
            ri_d_out      <= '0;
            vram_addr_out <= '0;
            vram_d_out    <= '0;
            vblank        <= 1'b0;
            nmi_out       <= 1'b0;
        end else begin
            ncs_q      <= ri_ncs_in;
            oam_wr_out <= 1'b0;
            vblank     <= vblank_nx;
            nmi_out    <= vblank_nx &
                          (wr_ctrl ? ri_d_in[CTRL_NMI_EN] : ctrl[CTRL_NMI_EN]);
            if (wr_ev) begin
                latch <= ri_d_in;
            end
            if (wr_ctrl) begin
                ctrl <= ri_d_in;
            end
            if (wr_mask) begin
                mask <= ri_d_in;
            end
            if (wr_oamaddr) begin
                oamaddr <= OAM_AW'(ri_d_in);
            end
            if (wr_oamdata) begin
                oam_d_out   <= ri_d_in;
                oam_wr_out  <= 1'b1;
                oam_wr_addr <= oamaddr;
                oamaddr     <= oamaddr + OAM_AW'(1);
            end
            if (data_go) begin
                vram_addr_out <= v[VRAM_AW-1:0];
                if (!ri_r_nw_in) begin
                    vram_d_out <= ri_d_in;
                end
            end
            if (rd_ack) begin
                buffer <= vram_d_in;
            end
            if (rd_ev && !pal_hit) begin
                ri_d_out <= rd_data;
            end else if (rd_ack && pal_pend) begin
                ri_d_out <= vram_d_in;
            end
        end
    end

endmodule
